// File: rtl/score_text_writer_if.sv
// Character RAM write port: address, glyph, active-low strobe and busy flag,
// grouped so the score writer and the text screen share one bundle.
interface score_text_writer_if;
    logic [11:0] oCharAddr;
    logic [7:0]  oCharData;
    logic        oChar_nWr;
    logic        oBusy;

    modport master (
        output oCharAddr,
        output oCharData,
        output oChar_nWr,
        output oBusy
    );

    modport slave (
        input oCharAddr,
        input oCharData,
        input oChar_nWr,
        input oBusy
    );
endinterface

// File: rtl/score_text_writer.sv
// Score glyph writer: snapshots scores/wins on change or restart and issues a
// four-character setup/strobe/hold write burst into the text-screen RAM.
module score_text_writer #(
    parameter logic [11:0] P1_ADDR = 12'h05B,
    parameter logic [11:0] P2_ADDR = 12'h06A
) (
    input  logic                        iVGA_CLK,
    input  logic                        iRST_n,
    input  logic                        start_n,
    input  logic [4:0]                  p1Score,
    input  logic [4:0]                  p2Score,
    input  logic                        p1Wins,
    input  logic                        p2Wins,
    score_text_writer_if.master         charBus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SNAP   = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state_r;
    logic [11:0] charAddr_r;
    logic [7:0]  charData_r;
    logic        charNwr_r;
    logic        busy_r;
    logic [4:0]  shadowP1_r;
    logic [4:0]  shadowP2_r;
    logic        shadowW1_r;
    logic        shadowW2_r;
    logic [4:0]  snapP1_r;
    logic [4:0]  snapP2_r;
    logic        snapW1_r;
    logic        snapW2_r;
    logic        refresh_r;
    logic [1:0]  idx_r;
    logic [1:0]  nextIdx_s;
    logic        trigger_s;

    // Tens digit by compare-and-subtract; a win replaces the score with "W ".
    function automatic logic [7:0] glyphCode(input logic [4:0] score,
                                             input logic       win,
                                             input logic       onesDigit);
        logic [7:0] tens;
        logic [4:0] rem;
        if (score >= 5'd30) begin
            tens = 8'h33;
            rem  = score - 5'd30;
        end else if (score >= 5'd20) begin
            tens = 8'h32;
            rem  = score - 5'd20;
        end else if (score >= 5'd10) begin
            tens = 8'h31;
            rem  = score - 5'd10;
        end else begin
            tens = 8'h20;
            rem  = score;
        end
        if (win) begin
            glyphCode = onesDigit ? 8'h20 : 8'h57;
        end else begin
            glyphCode = onesDigit ? (8'h30 + {3'b000, rem}) : tens;
        end
    endfunction

    function automatic logic [7:0] charFor(input logic [1:0] idx,
                                           input logic [4:0] s1, input logic [4:0] s2,
                                           input logic w1, input logic w2);
        case (idx)
            2'd0:    charFor = glyphCode(s1, w1, 1'b0);
            2'd1:    charFor = glyphCode(s1, w1, 1'b1);
            2'd2:    charFor = glyphCode(s2, w2, 1'b0);
            2'd3:    charFor = glyphCode(s2, w2, 1'b1);
            default: charFor = 8'h20;
        endcase
    endfunction

    function automatic logic [11:0] addrFor(input logic [1:0] idx);
        case (idx)
            2'd0:    addrFor = P1_ADDR;
            2'd1:    addrFor = P1_ADDR + 12'd1;
            2'd2:    addrFor = P2_ADDR;
            2'd3:    addrFor = P2_ADDR + 12'd1;
            default: addrFor = P1_ADDR;
        endcase
    endfunction

    assign nextIdx_s = idx_r + 2'd1;
    assign trigger_s = refresh_r
                     || (p1Score != shadowP1_r) || (p2Score != shadowP2_r)
                     || (p1Wins  != shadowW1_r) || (p2Wins  != shadowW2_r);

    // Burst sequencer with registered write-port outputs.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            state_r    <= IDLE;
            charAddr_r <= 12'h000;
            charData_r <= 8'h00;
            charNwr_r  <= 1'b1;
            busy_r     <= 1'b0;
            shadowP1_r <= 5'd0;
            shadowP2_r <= 5'd0;
            shadowW1_r <= 1'b0;
            shadowW2_r <= 1'b0;
            snapP1_r   <= 5'd0;
            snapP2_r   <= 5'd0;
            snapW1_r   <= 1'b0;
            snapW2_r   <= 1'b0;
            refresh_r  <= 1'b1;
            idx_r      <= 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (trigger_s) begin
                        state_r <= SNAP;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SNAP: begin
                    snapP1_r   <= p1Score;
                    snapP2_r   <= p2Score;
                    snapW1_r   <= p1Wins;
                    snapW2_r   <= p2Wins;
                    refresh_r  <= 1'b0;
                    idx_r      <= 2'd0;
                    // Char 0 is driven straight from the inputs being captured.
                    charAddr_r <= addrFor(2'd0);
                    charData_r <= charFor(2'd0, p1Score, p2Score, p1Wins, p2Wins);
                    state_r    <= SETUP;
                end
                SETUP: begin
                    charNwr_r <= 1'b0;
                    state_r   <= STROBE;
                end
                STROBE: begin
                    charNwr_r <= 1'b1;
                    state_r   <= HOLD;
                end
                HOLD: begin
                    if (idx_r != 2'd3) begin
                        idx_r      <= nextIdx_s;
                        charAddr_r <= addrFor(nextIdx_s);
                        charData_r <= charFor(nextIdx_s, snapP1_r, snapP2_r, snapW1_r, snapW2_r);
                        state_r    <= SETUP;
                    end else begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    shadowP1_r <= snapP1_r;
                    shadowP2_r <= snapP2_r;
                    shadowW1_r <= snapW1_r;
                    shadowW2_r <= snapW2_r;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    charNwr_r <= 1'b1;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
            // Restart request outranks the clear in SNAP so a held start_n re-runs.
            if (!start_n) begin
                refresh_r <= 1'b1;
            end else begin
                refresh_r <= (state_r == SNAP) ? 1'b0 : refresh_r;
            end
        end
    end

    assign charBus.oCharAddr = charAddr_r;
    assign charBus.oCharData = charData_r;
    assign charBus.oChar_nWr = charNwr_r;
    assign charBus.oBusy     = busy_r;

endmodule

// File: tb/tb_score_text_writer.sv
// Bench for score_text_writer: directed test-plan scenarios plus random
// input activity, checked every cycle against a burst-timeline reference model.
module tb_score_text_writer;

    logic       iVGA_CLK = 1'b0;
    logic       iRST_n   = 1'b0;
    logic       start_n  = 1'b1;
    logic [4:0] p1Score  = 5'd0;
    logic [4:0] p2Score  = 5'd0;
    logic       p1Wins   = 1'b0;
    logic       p2Wins   = 1'b0;

    score_text_writer_if bus ();

    score_text_writer #(.P1_ADDR(12'h05B), .P2_ADDR(12'h06A)) dut (
        .iVGA_CLK (iVGA_CLK),
        .iRST_n   (iRST_n),
        .start_n  (start_n),
        .p1Score  (p1Score),
        .p2Score  (p2Score),
        .p1Wins   (p1Wins),
        .p2Wins   (p2Wins),
        .charBus  (bus)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: position inside the 14-cycle burst timeline (0 = idle).
    int          mPhase   = 0;
    bit          mRefresh = 1'b1;
    int          mShadow[4];
    int          mSnap[4];
    logic [11:0] mAddr    = 12'h000;
    logic [7:0]  mData    = 8'h00;
    logic [19:0] wrLog[$];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] refGlyph(input int s, input int w, input bit ones);
        if (w != 0) return ones ? 8'h20 : 8'h57;
        if (ones) return 8'(8'h30 + s % 10);
        return (s < 10) ? 8'h20 : 8'(8'h30 + s / 10);
    endfunction

    function automatic bit inputsDiffer();
        return (int'(p1Score) != mShadow[0]) || (int'(p2Score) != mShadow[1])
            || (int'(p1Wins) != mShadow[2]) || (int'(p2Wins) != mShadow[3]);
    endfunction

    task automatic modelStep();
        int k;
        if (!iRST_n) begin
            mPhase = 0; mRefresh = 1'b1; mAddr = 12'h000; mData = 8'h00;
            for (int i = 0; i < 4; i++) begin mShadow[i] = 0; mSnap[i] = 0; end
        end else begin
            if (mPhase == 0) begin
                if (mRefresh || inputsDiffer()) mPhase = 1;
            end else if (mPhase == 1) begin
                mSnap[0] = p1Score; mSnap[1] = p2Score; mSnap[2] = p1Wins; mSnap[3] = p2Wins;
                mRefresh = 1'b0;
                mPhase = 2;
            end else if (mPhase == 14) begin
                mShadow = mSnap;
                mPhase = 0;
            end else begin
                mPhase++;
            end
            if (!start_n) mRefresh = 1'b1;
            if (mPhase >= 2 && mPhase <= 13) begin
                k = (mPhase - 2) / 3;
                mAddr = ((k < 2) ? 12'h05B : 12'h06A) + 12'(k % 2);
                mData = refGlyph(mSnap[(k / 2)], mSnap[2 + (k / 2)], bit'(k % 2));
            end
        end
    endtask

    task automatic tick();
        @(posedge iVGA_CLK);
        modelStep();
        #1;
        checkVal("busy", 32'(bus.oBusy), 32'(mPhase != 0));
        checkVal("nWr", 32'(bus.oChar_nWr),
                 32'(!(mPhase >= 3 && mPhase <= 12 && (mPhase % 3) == 0)));
        checkVal("addr", 32'(bus.oCharAddr), 32'(mAddr));
        checkVal("data", 32'(bus.oCharData), 32'(mData));
        if (bus.oChar_nWr === 1'b0) wrLog.push_back({bus.oCharAddr, bus.oCharData});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic waitPhase(input int target);
        for (int i = 0; i < 40 && mPhase != target; i++) tick();
        checkVal("waitPhase", 32'(mPhase), 32'(target));
    endtask

    initial begin
        int r;
        // Reset with 0/0 scores, then the forced refresh burst.
        ticks(3);
        iRST_n = 1'b1;
        wrLog.delete();
        ticks(20);
        checkVal("rstBurstCnt", 32'(wrLog.size()), 32'd4);
        if (wrLog.size() == 4) begin
            checkVal("rstW0", 32'(wrLog[0]), 32'h05B20);
            checkVal("rstW1", 32'(wrLog[1]), 32'h05C30);
            checkVal("rstW2", 32'(wrLog[2]), 32'h06A20);
            checkVal("rstW3", 32'(wrLog[3]), 32'h06B30);
        end

        // p1 score change while idle.
        wrLog.delete();
        p1Score = 5'd7;
        ticks(20);
        checkVal("p1ChgCnt", 32'(wrLog.size()), 32'd4);
        if (wrLog.size() == 4) checkVal("p1ChgOnes", 32'(wrLog[1]), 32'h05C37);

        // p2 score changed again mid-burst.
        wrLog.delete();
        p2Score = 5'd23;
        ticks(5);
        p2Score = 5'd31;
        ticks(40);
        checkVal("p2TwoBursts", 32'(wrLog.size()), 32'd8);
        if (wrLog.size() == 8) begin
            checkVal("p2B1Tens", 32'(wrLog[2]), 32'h06A32);
            checkVal("p2B1Ones", 32'(wrLog[3]), 32'h06B33);
            checkVal("p2B2Tens", 32'(wrLog[6]), 32'h06A33);
            checkVal("p2B2Ones", 32'(wrLog[7]), 32'h06B31);
        end

        // Player-1 win overrides the score digits.
        wrLog.delete();
        p1Wins = 1'b1;
        p1Score = 5'd12;
        ticks(20);
        if (wrLog.size() >= 2) begin
            checkVal("winTens", 32'(wrLog[0]), 32'h05B57);
            checkVal("winOnes", 32'(wrLog[1]), 32'h05C20);
        end else begin
            checkVal("winCnt", 32'(wrLog.size()), 32'd4);
        end

        // start_n pulse during char 2 causes one extra identical burst.
        wrLog.delete();
        p1Wins = 1'b0;
        waitPhase(8);
        start_n = 1'b0;
        tick();
        start_n = 1'b1;
        ticks(40);
        checkVal("restartCnt", 32'(wrLog.size()), 32'd8);

        // Reset during the strobe of char 1 abandons the burst.
        p2Score = 5'd4;
        waitPhase(6);
        iRST_n = 1'b0;
        tick();
        iRST_n = 1'b1;
        checkVal("rstMidNwr", 32'(bus.oChar_nWr), 32'd1);
        checkVal("rstMidBusy", 32'(bus.oBusy), 32'd0);
        wrLog.delete();
        ticks(20);
        checkVal("rstMidCnt", 32'(wrLog.size()), 32'd4);

        // Random activity.
        for (int c = 0; c < 1500; c++) begin
            r = $urandom_range(0, 199);
            start_n = 1'b1;
            iRST_n  = 1'b1;
            if (r < 4)       p1Score = 5'($urandom_range(0, 31));
            else if (r < 8)  p2Score = 5'($urandom_range(0, 31));
            else if (r < 9)  p1Wins  = ~p1Wins;
            else if (r < 10) p2Wins  = ~p2Wins;
            else if (r < 12) start_n = 1'b0;
            else if (r == 199) iRST_n = 1'b0;
            else begin end
            tick();
        end
        start_n = 1'b1;
        iRST_n  = 1'b1;
        ticks(40);
        checkVal("finalIdle", 32'(bus.oBusy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/score_text_writer.md
# score_text_writer

Character-write sequencer that sits directly upstream of the text-screen character RAM port and renders both players' scores as ASCII glyphs. It watches the score and win inputs and, when they change or a refresh is forced, snapshots them. It then issues a fixed four-character write burst on the addr/data/nWr port with a clean setup/strobe/hold pattern. This takes the score-update state machine out of the VGA controller and guarantees tear-free, race-free updates.

## Interface
Parameters:
- P1_ADDR, 12'h05B: character address of player-1 tens glyph; ones glyph at P1_ADDR+1.
- P2_ADDR, 12'h06A: character address of player-2 tens glyph; ones glyph at P2_ADDR+1.

Ports:
- iVGA_CLK  in  1  sole clock; all logic on its rising edge.
- iRST_n  in  1  reset; synchronous and active-low.
- start_n  in  1  game restart, active-low, synchronous level; forces a refresh.
- p1Score  in  5  player-1 score, unsigned 0..31.
- p2Score  in  5  player-2 score, unsigned 0..31.
- p1Wins  in  1  player-1 win flag.
- p2Wins  in  1  player-2 win flag.
- oCharAddr  out  12  character RAM address, registered.
- oCharData  out  8  ASCII glyph code, registered.
- oChar_nWr  out  1  write strobe, active-low, registered.
- oBusy  out  1  high while a burst is in progress, registered.

## Operation
- State registers:
  - shadow scores/wins of the last burst.
  - snapshot registers.
  - char index 0..3.
  - refresh_req flag.
- States:
  - IDLE: if refresh_req, or any input differs from shadow, go to SNAP; otherwise stay.
  - SNAP: capture p1Score, p2Score, p1Wins, p2Wins into the snapshot; clear refresh_req; index=0; go to SETUP.
  - SETUP: drive addr/data for the current index; oChar_nWr=1.
  - STROBE: oChar_nWr=0, addr/data held.
  - HOLD: oChar_nWr=1, addr/data held. If index<3, index+1 and go to SETUP; else go to DONE.
  - DONE: shadow <= snapshot; go to IDLE.
- Character order:
  - index0 = P1_ADDR (p1 tens)
  - index1 = P1_ADDR+1 (p1 ones)
  - index2 = P2_ADDR (p2 tens)
  - index3 = P2_ADDR+1 (p2 ones)
- Glyph encoding from the snapshot:
  - Win flag set: tens 8'h57 'W', ones 8'h20 ' '.
  - Score 0..9: tens 8'h20, ones 8'h30+s.
  - Score 10..19: tens 8'h31, ones 8'h30+(s-10).
  - Score 20..29: tens 8'h32, ones 8'h30+(s-20).
  - Score 30..31: tens 8'h33, ones 8'h30+(s-30).
  - Tens/ones are computed by compare-and-subtract; no divider.
- Inputs are sampled only in IDLE (compare) and SNAP (capture). Changes during a burst do not alter that burst; the next IDLE compare against the updated shadow triggers a new burst.
- refresh_req:
  - Set by reset.
  - Set in any cycle with start_n=0, including mid-burst. This never aborts a burst.
  - Cleared only in SNAP. If start_n is still low in SNAP, the set wins and another pass follows.
- Reset (iRST_n=0 at an edge), from any state:
  - state IDLE, oChar_nWr=1, oBusy=0, oCharAddr=0, oCharData=0.
  - shadow = 0, snapshot = 0, refresh_req = 1.
  - A burst in flight is abandoned; no partial strobe is emitted.

## Timing
- Let IDLE detect a trigger at edge t. Then:
  - SNAP at t+1, oBusy=1.
  - First SETUP at t+2; char k STROBE (oChar_nWr low) at t+3+3k, k=0..3.
  - Last HOLD at t+13, DONE at t+14, IDLE at t+15 with oBusy=0.
- Burst = 14 busy cycles.
- oChar_nWr is low for exactly 1 cycle per character. oCharAddr/oCharData are stable from 1 cycle before the strobe to 1 cycle after it.
- Minimum spacing between back-to-back bursts: one IDLE cycle.
- Outputs hold their last values in IDLE. oChar_nWr=1 outside STROBE.

## Test plan
- Reset release with scores 0/0, no wins: 4 strobes, at 05B=20, 05C=30, 06A=20, 06B=30; oBusy high 14 cycles; then idle with no further strobes.
- p1Score 0→7 while idle: strobes begin 3 cycles after the change edge; 05C=37, other three chars rewritten unchanged; exactly one burst.
- p2Score=23 then p2Score=31 mid-burst: first burst writes 06A=32, 06B=33; a second burst follows after 1 IDLE cycle and writes 06A=33, 06B=31.
- p1Wins=1 with p1Score=12: 05B=57, 05C=20.
- start_n pulsed low for 1 cycle during char 2 of a burst: that burst completes all 4 strobes, then one extra full burst runs with identical data.
- iRST_n low for 1 cycle during STROBE of char 1: oChar_nWr=1 next cycle, oBusy=0; a fresh full burst starts after reset release.
